// File: rtl/ce_pkg.sv
// Clock-enable bundle constants and the phase -> expected-enable decode.
// Shared by the phase monitor and the generator bench.
package ce_pkg;

    localparam int         PERIOD     = 64;
    localparam logic [5:0] SYNC_PHASE = 6'd32;

    localparam int CE12_BIT  = 0;
    localparam int CE6_BIT   = 1;
    localparam int CE6X_BIT  = 2;
    localparam int CE3_BIT   = 3;
    localparam int CE3F2_BIT = 4;
    localparam int VIDEO_BIT = 5;
    localparam int PIPE_BIT  = 6;
    localparam int CE1M5_BIT = 7;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_VERIFY,
        ST_LOCKED
    } mon_state_t;

    // Enables the generator presents in the cycle after its counter held p.
    function automatic logic [7:0] ce_expected(input logic [5:0] p);
        logic [7:0] v;
        v            = 8'h00;
        v[CE12_BIT]  = p[0];
        v[CE6_BIT]   = p[1] & p[0];
        v[CE6X_BIT]  = p[1] & ~p[0];
        v[CE3_BIT]   = (p[2:0] == 3'b110);
        v[CE3F2_BIT] = (p[2:0] == 3'b111);
        v[VIDEO_BIT] = ~p[2];
        v[PIPE_BIT]  = p[5];
        v[CE1M5_BIT] = (p[3:0] == 4'b0110);
        return v;
    endfunction

endpackage

// File: rtl/ce_expect.sv
// Combinational decode of the tracked phase into the expected enable vector.
module ce_expect
    import ce_pkg::*;
(
    input  logic [5:0] phase,
    output logic [7:0] exp_vec
);

    assign exp_vec = ce_expected(phase);

endmodule

// File: rtl/ce_phase_monitor.sv
// Recovers the 6-bit master phase from the clk24 enable bundle and checks every cycle; outputs registered, no backpressure.
// Define CE_PHASE_MONITOR_STICKY_EN to make err_mask accumulate all mismatching bits until the next lock.
module ce_phase_monitor
    import ce_pkg::*;
#(
    parameter int LOCK_PERIODS = 2,
    parameter int LOSS_LIMIT   = 3,
    parameter int ERR_W        = 16
) (
    input  logic             clk24,
    input  logic             reset,
    input  logic             ce12,
    input  logic             ce6,
    input  logic             ce6x,
    input  logic             ce3,
    input  logic             ce3f2,
    input  logic             video_slice,
    input  logic             pipe_ab,
    input  logic             ce1m5,
    output logic             locked,
    output logic [5:0]       phase,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       err_mask
);

    localparam int CLEAN_W = $clog2(LOCK_PERIODS + 1);
    localparam int LOSS_W  = $clog2(LOSS_LIMIT + 1);

    mon_state_t         state, state_nxt;
    logic               prev_pipe;
    logic [CLEAN_W-1:0] clean_cnt, clean_nxt;
    logic [LOSS_W-1:0]  loss_cnt, loss_nxt;
    logic [5:0]         phase_nxt;
    logic [7:0]         obs_vec, exp_vec, diff_vec, mask_nxt;
    logic               bad, wrap, sync_edge;

    assign obs_vec   = {ce1m5, pipe_ab, video_slice, ce3f2, ce3, ce6x, ce6, ce12};
    assign diff_vec  = obs_vec ^ exp_vec;
    assign bad       = (state != ST_HUNT) && (diff_vec != 8'h00);
    assign wrap      = (phase == 6'(PERIOD - 1));
    assign sync_edge = (state == ST_HUNT) && !prev_pipe && pipe_ab;
    assign locked    = (state == ST_LOCKED);

    ce_expect u_expect (
        .phase   (phase),
        .exp_vec (exp_vec)
    );

    always_comb begin
        state_nxt = state;
        clean_nxt = clean_cnt;
        loss_nxt  = loss_cnt;
        phase_nxt = phase + 6'd1;
        case (state)
            ST_HUNT: begin
                // pipe_ab first rises in the cycle carrying p=32
                if (sync_edge) begin
                    state_nxt = ST_VERIFY;
                    phase_nxt = SYNC_PHASE + 6'd1;
                end
            end
            ST_VERIFY: begin
                if (bad) begin
                    state_nxt = ST_HUNT;
                    clean_nxt = '0;
                end else if (wrap) begin
                    if (clean_cnt == CLEAN_W'(LOCK_PERIODS - 1)) begin
                        state_nxt = ST_LOCKED;
                        clean_nxt = '0;
                        loss_nxt  = '0;
                    end else begin
                        clean_nxt = clean_cnt + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                // a loss-limit hit outranks the wrap that would clear the loss count
                if (bad && (loss_cnt == LOSS_W'(LOSS_LIMIT - 1))) begin
                    state_nxt = ST_HUNT;
                    loss_nxt  = '0;
                end else if (wrap) begin
                    loss_nxt = '0;
                end else if (bad) begin
                    loss_nxt = loss_cnt + 1'b1;
                end
            end
            default: state_nxt = ST_HUNT;
        endcase
    end

`ifdef CE_PHASE_MONITOR_STICKY_EN
    assign mask_nxt = (state_nxt == ST_LOCKED && state != ST_LOCKED) ? 8'h00 :
                      bad ? (err_mask | diff_vec) : err_mask;
`else
    assign mask_nxt = bad ? diff_vec : err_mask;
`endif

    always_ff @(posedge clk24 or posedge reset) begin
        if (reset) begin
            state     <= ST_HUNT;
            prev_pipe <= 1'b0;
            clean_cnt <= '0;
            loss_cnt  <= '0;
            phase     <= 6'd0;
            mismatch  <= 1'b0;
            err_count <= '0;
            err_mask  <= 8'h00;
        end else begin
            state     <= state_nxt;
            prev_pipe <= pipe_ab;
            clean_cnt <= clean_nxt;
            loss_cnt  <= loss_nxt;
            phase     <= phase_nxt;
            mismatch  <= bad;
            err_mask  <= mask_nxt;
            if (bad && (err_count != '1)) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule
